pipelined_prefetch: RTL and testbench

Next-generation instruction fetch for the ZipCPU core: a pipelined Wishbone (B4 pipelined) master that streams sequential instruction words into a parametrised on-chip FIFO ahead of the decoder.
- Multiple reads stay outstanding; the CPU consumes one word per clock when not stalled.
- A branch or redirect flushes all in-flight and buffered words and restarts fetching at the new PC.
- Bus errors are carried to the CPU as an illegal-instruction flag alongside the word.

---
 rtl/zipcpu_prefetch_pkg.sv | 25 ++
 rtl/prefetch_sfifo.sv | 83 ++++++++
 rtl/pipelined_prefetch.sv | 187 ++++++++++++++++++
 tb/tb_pipelined_prefetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zipcpu_prefetch_pkg.sv
// Shared definitions for the pipelined instruction prefetch.
// Holds the default address/data widths and FIFO depth, the layout of
// one buffered fetch entry, and the fetch-engine state encoding.
package zipcpu_prefetch_pkg;

  localparam int PF_AW      = 32;
  localparam int PF_DW      = 32;
  localparam int PF_LGDEPTH = 2;

  // One buffered instruction: bus-error flag, its address, and the word.
  typedef struct packed {
    logic              illegal;
    logic [PF_AW-1:0]  pc;
    logic [PF_DW-1:0]  insn;
  } pf_entry_t;

  // IDLE: no bus activity until a redirect. FETCH: streaming.
  // ABORT: one dead cycle with cyc low after a redirect mid-cycle.
  typedef enum logic [1:0] {
    PF_IDLE  = 2'b00,
    PF_FETCH = 2'b01,
    PF_ABORT = 2'b10
  } pf_state_e;

endpackage

// File: rtl/prefetch_sfifo.sv
// Synchronous first-word-fall-through FIFO for fetched instructions.
// Ports:
//   clk_i, rst_i     clock and synchronous active-high reset
//   push_i, data_i   write one entry (ignored when full unless popping)
//   pop_i            discard head entry (ignored when empty)
//   flush_i          empty the FIFO; dominates push and pop
//   data_o           head entry, straight from the storage registers
//   count_o          number of stored entries (0..DEPTH)
//   empty_o, full_o  status flags
module prefetch_sfifo #(
  parameter int LGDEPTH = 2,
  parameter int WIDTH   = 65
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]   data_o,
  output logic [LGDEPTH:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] DEPTH_C = (LGDEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LGDEPTH:0]   count_q, count_d;
  logic               do_push_s, do_pop_s;

  // Next-state for pointers and occupancy; flush wins over everything.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop_i && (count_q != {(LGDEPTH+1){1'b0}});
    do_push_s = push_i && ((count_q != DEPTH_C) || do_pop_s);
    if (flush_i) begin
      wr_ptr_d = {LGDEPTH{1'b0}};
      rd_ptr_d = {LGDEPTH{1'b0}};
      count_d  = {(LGDEPTH+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + LGDEPTH'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + LGDEPTH'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (LGDEPTH+1)'(1);
        2'b01:   count_d = count_q - (LGDEPTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {LGDEPTH{1'b0}};
      rd_ptr_q <= {LGDEPTH{1'b0}};
      count_q  <= {(LGDEPTH+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates validity.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == {(LGDEPTH+1){1'b0}});
  assign full_o  = (count_q == DEPTH_C);

endmodule

// File: rtl/pipelined_prefetch.sv
// Pipelined Wishbone instruction prefetch: keeps several sequential reads
// outstanding and buffers the returned words in a small FIFO ahead of the
// decoder. A redirect flushes everything and restarts at the new PC; a bus
// error is delivered as an entry flagged illegal and halts fetching.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_new_pc, i_pc               redirect strobe and target
//   i_stalled_n                  consumer ready (pops when o_valid)
//   o_valid, o_i, o_pc, o_illegal  head-of-FIFO instruction
//   o_wb_*, i_wb_*               Wishbone B4 pipelined read master
module pipelined_prefetch
  import zipcpu_prefetch_pkg::*;
#(
  parameter int AW      = PF_AW,
  parameter int DW      = PF_DW,
  parameter int LGDEPTH = PF_LGDEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_new_pc,
  input  logic [AW-1:0] i_pc,
  input  logic          i_stalled_n,
  output logic          o_valid,
  output logic [DW-1:0] o_i,
  output logic [AW-1:0] o_pc,
  output logic          o_illegal,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH+1:0] DEPTH_S = (LGDEPTH+2)'(DEPTH);

  typedef struct packed {
    logic          illegal;
    logic [AW-1:0] pc;
    logic [DW-1:0] insn;
  } entry_t;

  pf_state_e        state_q, state_d;
  logic             cyc_q, cyc_d, stb_q, stb_d;
  logic [AW-1:0]    addr_q, addr_d;          // next request address
  logic [AW-1:0]    rsp_addr_q, rsp_addr_d;  // address of next response
  logic [AW-1:0]    pend_pc_q, pend_pc_d;    // target held across abort
  logic [LGDEPTH:0] outst_q, outst_d;

  logic             accept_s, ack_s, err_s;
  logic             push_s, flush_s, pop_s, empty_s, full_s;
  logic [LGDEPTH:0] count_s;
  logic [LGDEPTH+1:0] sum_s;
  entry_t           push_entry_s, head_s;

  // Responses only count while our own cycle is open; anything arriving
  // with cyc low belongs to an aborted stream.
  assign accept_s = stb_q && !i_wb_stall;
  assign ack_s    = cyc_q && i_wb_ack;
  assign err_s    = cyc_q && i_wb_err;
  assign pop_s    = !empty_s && i_stalled_n;

  // Slots already promised: in flight + buffered + the one issuing now.
  assign sum_s = {1'b0, outst_q} + {1'b0, count_s}
               + {{(LGDEPTH+1){1'b0}}, accept_s};

  // Fetch engine next-state and bus request logic.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    addr_d     = addr_q;
    rsp_addr_d = rsp_addr_q;
    pend_pc_d  = pend_pc_q;
    outst_d    = outst_q;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    push_entry_s.illegal = 1'b0;
    push_entry_s.pc      = rsp_addr_q;
    push_entry_s.insn    = i_wb_data;
    case (state_q)
      PF_IDLE: begin
        if (i_new_pc) begin
          flush_s = 1'b1; state_d = PF_FETCH; cyc_d = 1'b1; stb_d = 1'b1;
          addr_d = i_pc; rsp_addr_d = i_pc; outst_d = '0;
        end else begin
          cyc_d = 1'b0; stb_d = 1'b0;
        end
      end
      PF_ABORT: begin
        // A redirect arriving in the dead cycle simply supersedes the held one.
        flush_s = 1'b1; state_d = PF_FETCH; cyc_d = 1'b1; stb_d = 1'b1;
        outst_d = '0;
        if (i_new_pc) begin
          addr_d = i_pc; rsp_addr_d = i_pc;
        end else begin
          addr_d = pend_pc_q; rsp_addr_d = pend_pc_q;
        end
      end
      PF_FETCH: begin
        if (i_new_pc) begin
          flush_s = 1'b1;
          if (cyc_q) begin
            // Drop the cycle for one clock so the slave forgets old requests.
            state_d = PF_ABORT; cyc_d = 1'b0; stb_d = 1'b0;
            pend_pc_d = i_pc; outst_d = '0;
          end else begin
            cyc_d = 1'b1; stb_d = 1'b1;
            addr_d = i_pc; rsp_addr_d = i_pc; outst_d = '0;
          end
        end else if (err_s) begin
          push_s = 1'b1; push_entry_s.illegal = 1'b1;
          state_d = PF_IDLE; cyc_d = 1'b0; stb_d = 1'b0; outst_d = '0;
        end else begin
          if (accept_s) addr_d = addr_q + AW'(1);
          else          addr_d = addr_q;
          if (ack_s) begin
            push_s = 1'b1; rsp_addr_d = rsp_addr_q + AW'(1);
          end else begin
            rsp_addr_d = rsp_addr_q;
          end
          outst_d = outst_q + {{LGDEPTH{1'b0}}, accept_s}
                            - {{LGDEPTH{1'b0}}, ack_s};
          stb_d   = !full_s && (sum_s < DEPTH_S);
          cyc_d   = stb_d || (outst_d != '0);
        end
      end
      default: begin
        state_d = PF_IDLE; cyc_d = 1'b0; stb_d = 1'b0;
        outst_d = '0; flush_s = 1'b1;
      end
    endcase
  end

  // Fetch engine registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= PF_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      addr_q     <= '1;
      rsp_addr_q <= '1;
      pend_pc_q  <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
      rsp_addr_q <= rsp_addr_d;
      pend_pc_q  <= pend_pc_d;
      outst_q    <= outst_d;
    end
  end

  prefetch_sfifo #(
    .LGDEPTH(LGDEPTH),
    .WIDTH  (1 + AW + DW)
  ) u_fifo (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .push_i (push_s),
    .pop_i  (pop_s),
    .flush_i(flush_s),
    .data_i (push_entry_s),
    .data_o (head_s),
    .count_o(count_s),
    .empty_o(empty_s),
    .full_o (full_s)
  );

  assign o_valid   = !empty_s;
  assign o_i       = head_s.insn;
  assign o_pc      = head_s.pc;
  assign o_illegal = !empty_s && head_s.illegal;

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = 1'b0;
  assign o_wb_addr = addr_q;
  assign o_wb_data = '0;

endmodule

// File: tb/tb_pipelined_prefetch.sv
module tb_pipelined_prefetch;

  logic        i_clk, i_rst, i_new_pc, i_stalled_n;
  logic [31:0] i_pc;
  logic        o_valid, o_illegal, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_i, o_pc, o_wb_addr, o_wb_data;
  logic        i_wb_ack, i_wb_stall, i_wb_err;
  logic [31:0] i_wb_data;

  int total = 0;
  int bad   = 0;

  pipelined_prefetch dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_new_pc(i_new_pc), .i_pc(i_pc),
    .i_stalled_n(i_stalled_n), .o_valid(o_valid), .o_i(o_i), .o_pc(o_pc),
    .o_illegal(o_illegal), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- Wishbone slave model ----------------
  typedef struct { logic [31:0] addr; int ready; } req_t;
  req_t        q[$];
  logic [31:0] req_log[$];
  int          cnum = 0, acc_total = 0, stall_at = 32'h3fff_ffff, max_delay = 0;
  bit          hold = 0, keep_stale = 0, rand_stall = 0, err_en = 0, err_fired = 0;
  logic [31:0] err_addr = 32'h0;

  initial begin
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'h0;
    forever begin
      @(negedge i_clk);
      cnum++;
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;
      if (!i_rst && (o_wb_cyc || keep_stale) && !hold && q.size() > 0 && q[0].ready <= cnum) begin
        if (err_en && q[0].addr == err_addr) begin
          i_wb_err = 1'b1; err_fired = 1'b1; q.delete();
        end else begin
          i_wb_ack = 1'b1; i_wb_data = data_of(q[0].addr); q.delete(0);
        end
      end
      if (!o_wb_cyc) q.delete();
      i_wb_stall = (rand_stall && $urandom_range(0, 2) == 0) || (acc_total >= stall_at);
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        q.push_back('{addr: o_wb_addr,
                      ready: cnum + 1 + ((max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0)});
        req_log.push_back(o_wb_addr);
        acc_total++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_new_pc = 1'b1; i_pc = pc;
    tick();
    i_new_pc = 1'b0; i_pc = 32'h0;
    req_log.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1; i_new_pc = 1'b0; i_pc = 32'h0; i_stalled_n = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    total++; if (o_wb_cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc got %b want 0", o_wb_cyc); end
    total++; if (o_wb_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got %b want 0", o_wb_stb); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", o_valid); end
    total++; if (o_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got %b want 0", o_illegal); end
    total++; if (o_wb_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_addr got %h want ffffffff", o_wb_addr); end
    total++; if (o_wb_we !== 1'b0 || o_wb_data !== 32'h0) begin bad++; $display("FAIL reset_we_data got %b/%h want 0/0", o_wb_we, o_wb_data); end
    repeat (5) tick();
    total++; if (o_wb_cyc !== 1'b0 || req_log.size() != 0) begin bad++; $display("FAIL idle_no_fetch got cyc=%b reqs=%0d want 0/0", o_wb_cyc, req_log.size()); end
  endtask

  task automatic test_stream();
    logic [31:0] exp = 32'h100;
    int first = -1;
    redirect(32'h100);
    total++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1 || o_wb_addr !== 32'h100) begin
      bad++; $display("FAIL stream_start got cyc=%b stb=%b addr=%h want 1/1/100", o_wb_cyc, o_wb_stb, o_wb_addr); end
    for (int c = 0; c < 40 && exp != 32'h108; c++) begin
      if (o_valid) begin
        if (first < 0) first = c;
        total++; if (o_pc !== exp || o_i !== data_of(exp) || o_illegal !== 1'b0) begin
          bad++; $display("FAIL stream_word got pc=%h i=%h il=%b want pc=%h i=%h il=0", o_pc, o_i, o_illegal, exp, data_of(exp)); end
        exp++;
      end else if (first >= 0) begin
        total++; bad++; $display("FAIL stream_gap got o_valid=0 want 1 at pc=%h", exp);
      end
      tick();
    end
    total++; if (exp != 32'h108) begin bad++; $display("FAIL stream_timeout got %h want 108", exp); end
    total++; if (first != 2) begin bad++; $display("FAIL stream_latency got %0d want 2", first); end
    for (int i = 0; i < 8; i++) begin
      total++; if (req_log.size() <= i || req_log[i] !== 32'h100 + i) begin
        bad++; $display("FAIL stream_req got %h want %h", (req_log.size() > i) ? req_log[i] : 32'hx, 32'h100 + i); end
    end
  endtask

  task automatic test_stall_fill();
    bit seen = 0;
    logic [31:0] exp = 32'h100;
    i_stalled_n = 1'b0;
    redirect(32'h100);
    total++; if (o_wb_cyc !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL stall_abort got cyc=%b valid=%b want 0/0", o_wb_cyc, o_valid); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_valid) seen = 1;
      if (seen) begin
        total++; if (o_valid !== 1'b1 || o_pc !== 32'h100) begin
          bad++; $display("FAIL stall_hold got valid=%b pc=%h want 1/100", o_valid, o_pc); end
      end
    end
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL stall_reqs got %0d want 4", req_log.size()); end
    i_stalled_n = 1'b1;
    for (int c = 0; c < 30 && exp != 32'h106; c++) begin
      if (o_valid) begin
        total++; if (o_pc !== exp || o_i !== data_of(exp)) begin
          bad++; $display("FAIL stall_drain got pc=%h i=%h want %h/%h", o_pc, o_i, exp, data_of(exp)); end
        exp++;
      end
      tick();
    end
    total++; if (exp != 32'h106) begin bad++; $display("FAIL stall_drain_timeout got %h want 106", exp); end
  endtask

  task automatic test_redirect();
    hold = 1; stall_at = 32'h3fff_ffff;
    redirect(32'h100);
    stall_at = acc_total + 3;
    for (int c = 0; c < 20 && req_log.size() < 3; c++) tick();
    tick();
    total++; if (req_log.size() != 3) begin bad++; $display("FAIL redir_outstanding got %0d want 3", req_log.size()); end
    i_new_pc = 1'b1; i_pc = 32'h200; hold = 0; keep_stale = 1; stall_at = 32'h3fff_ffff;
    tick();
    i_new_pc = 1'b0; i_pc = 32'h0;
    total++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL redir_abort got cyc=%b stb=%b valid=%b want 0/0/0", o_wb_cyc, o_wb_stb, o_valid); end
    tick();
    keep_stale = 0;
    total++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1 || o_wb_addr !== 32'h200) begin
      bad++; $display("FAIL redir_restart got cyc=%b stb=%b addr=%h want 1/1/200", o_wb_cyc, o_wb_stb, o_wb_addr); end
    for (int c = 0; c < 10 && !o_valid; c++) tick();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_i !== data_of(32'h200)) begin
      bad++; $display("FAIL redir_first got valid=%b pc=%h i=%h want 1/200/%h", o_valid, o_pc, o_i, data_of(32'h200)); end
  endtask

  task automatic test_bus_error();
    int idx = 0, n;
    bit err_seen = 0;
    err_en = 1; err_addr = 32'h102; err_fired = 0;
    redirect(32'h100);
    for (int c = 0; c < 30 && idx < 3; c++) begin
      if (err_fired) begin
        err_fired = 0; err_seen = 1;
        total++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin
          bad++; $display("FAIL err_drop got cyc=%b stb=%b want 0/0", o_wb_cyc, o_wb_stb); end
      end
      if (o_valid) begin
        total++; if (o_pc !== 32'h100 + idx || o_illegal !== (idx == 2)) begin
          bad++; $display("FAIL err_word got pc=%h il=%b want %h/%b", o_pc, o_illegal, 32'h100 + idx, idx == 2); end
        if (idx < 2) begin
          total++; if (o_i !== data_of(32'h100 + idx)) begin
            bad++; $display("FAIL err_data got %h want %h", o_i, data_of(32'h100 + idx)); end
        end
        idx++;
      end
      tick();
    end
    total++; if (!err_seen || idx != 3) begin bad++; $display("FAIL err_seq got err=%0d words=%0d want 1/3", err_seen, idx); end
    n = req_log.size();
    repeat (8) tick();
    total++; if (req_log.size() != n || o_wb_cyc !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL err_halt got reqs=%0d cyc=%b valid=%b want %0d/0/0", req_log.size(), o_wb_cyc, o_valid, n); end
    err_en = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp = 32'hFFFF_FFFE;
    int idx = 0;
    redirect(32'hFFFF_FFFE);
    for (int c = 0; c < 20 && idx < 3; c++) begin
      if (o_valid) begin
        total++; if (o_pc !== exp || o_i !== data_of(exp)) begin
          bad++; $display("FAIL wrap_word got pc=%h i=%h want %h/%h", o_pc, o_i, exp, data_of(exp)); end
        exp++; idx++;
      end
      tick();
    end
    total++; if (idx != 3 || exp !== 32'h1) begin bad++; $display("FAIL wrap_count got %0d want 3", idx); end
  endtask

  task automatic test_random();
    logic [31:0] exp = 32'h300;
    int pops = 0;
    rand_stall = 1; max_delay = 3;
    redirect(32'h300);
    for (int c = 0; c < 400; c++) begin
      total++; if (req_log.size() - pops > 4) begin
        bad++; $display("FAIL rand_occupancy got %0d want <=4", req_log.size() - pops); end
      i_stalled_n = ($urandom_range(0, 3) != 0);
      if (o_valid && i_stalled_n) begin
        total++; if (o_pc !== exp || o_i !== data_of(exp) || o_illegal !== 1'b0) begin
          bad++; $display("FAIL rand_word got pc=%h i=%h il=%b want %h/%h/0", o_pc, o_i, o_illegal, exp, data_of(exp)); end
        exp++; pops++;
      end
      tick();
    end
    total++; if (pops < 50) begin bad++; $display("FAIL rand_progress got %0d want >=50", pops); end
    for (int i = 0; i < req_log.size(); i++) begin
      total++; if (req_log[i] !== 32'h300 + i) begin
        bad++; $display("FAIL rand_req got %h want %h", req_log[i], 32'h300 + i); end
    end
    rand_stall = 0; max_delay = 0; i_stalled_n = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1; i_new_pc = 1'b0; i_pc = 32'h0; i_stalled_n = 1'b1;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect();
    test_bus_error();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
